// File: rtl/dbg_uart_pkg.sv
// Shared constants and types for the debugger UART byte buffer.
package dbg_uart_pkg;

  // Status register bit positions
  localparam int unsigned StatRxNonempty = 0;
  localparam int unsigned StatTxFull     = 1;
  localparam int unsigned StatRxOverflow = 2;
  localparam int unsigned StatTxError    = 3;
  localparam int unsigned StatTxIdle     = 4;
  localparam int unsigned StatRxCount    = 5;

  // Control write bit positions
  localparam int unsigned CtrlClearFlags = 0;
  localparam int unsigned CtrlFlushRx    = 1;
  localparam int unsigned CtrlFlushTx    = 2;

  // Valid flag position inside rx_rd_data
  localparam int unsigned RxValidBit = 15;

  // Transmit pacing FSM
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_LOAD  = 2'd1,
    TX_DRAIN = 2'd2
  } tx_state_e;

endpackage

// File: rtl/dbg_byte_fifo.sv
// 8-bit synchronous FIFO with flush, occupancy count and combinational head.
module dbg_byte_fifo #(
  parameter int unsigned DepthLog2 = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [7:0]         wdata_i,
  output logic [7:0]         head_o,
  output logic [DepthLog2:0] count_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int unsigned Depth = 1 << DepthLog2;
  localparam int unsigned PtrW  = DepthLog2;
  localparam int unsigned CntW  = DepthLog2 + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [7:0]      mem_q [Depth];
  logic [7:0]      mem_d [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            pop_ok, push_ok;

  // Next-state: a pop frees a slot, so a push at full with a pop is accepted
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    pop_ok  = pop_i & (count_q != '0);
    push_ok = push_i & ((count_q != CntFull) | pop_ok);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  // Pointer and occupancy state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care while unoccupied
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Status and head outputs
  always_comb begin
    head_o  = mem_q[rptr_q];
    count_o = count_q;
    full_o  = (count_q == CntFull);
    empty_o = (count_q == '0);
  end

endmodule

// File: rtl/dbg_uart_buffer.sv
// Byte buffering between the visor register bus and the debugger UART cores.
// RX bytes are captured on the receiver's busy falling edge; TX bytes are
// paced into the transmitter with a load/busy handshake and a load timeout.
module dbg_uart_buffer
  import dbg_uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TX_TIMEOUT = 1024
) (
  input  logic        sysclk,
  input  logic        sysreset_n,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_busy,
  input  logic        uart_tx_busy,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_load,
  output logic [15:0] rx_rd_data,
  input  logic        rx_pop,
  input  logic [7:0]  tx_wr_data,
  input  logic        tx_push,
  input  logic        ctrl_wr,
  input  logic [2:0]  ctrl_data,
  output logic [15:0] status
);
  localparam int unsigned CntW = $clog2(TX_TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TX_TIMEOUT - 1);

  // Busy synchronizers: [0] first flop, [1] second, [2] edge-detect history
  logic [2:0] rx_sync_q, rx_sync_d;
  logic [1:0] tx_sync_q, tx_sync_d;
  logic       rx_fall, tx_busy_s;

  logic       clear_flags, flush_rx, flush_tx;
  logic       rx_pop_ok, rx_ovf_set, tx_err_set, tx_push_ok, tx_pop;
  logic       rx_ovf_q, rx_ovf_d;
  logic       tx_err_q, tx_err_d;

  tx_state_e       tx_state_q, tx_state_d;
  logic            tx_load_q, tx_load_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [7:0]          rx_head, tx_head;
  logic [DEPTH_LOG2:0] rx_count, tx_count;
  logic                rx_full, rx_empty, tx_full, tx_empty;
  logic                unused_tx_count;

  // Control decode, synchronizer shift and RX capture/overflow detection
  always_comb begin
    clear_flags = ctrl_wr & ctrl_data[CtrlClearFlags];
    flush_rx    = ctrl_wr & ctrl_data[CtrlFlushRx];
    flush_tx    = ctrl_wr & ctrl_data[CtrlFlushTx];
    rx_sync_d   = {rx_sync_q[1:0], uart_rx_busy};
    tx_sync_d   = {tx_sync_q[0], uart_tx_busy};
    rx_fall     = rx_sync_q[2] & ~rx_sync_q[1];
    tx_busy_s   = tx_sync_q[1];
    rx_pop_ok   = rx_pop & ~rx_empty;
    // A capture at full is lost unless a pop makes room the same cycle
    rx_ovf_set  = rx_fall & rx_full & ~rx_pop_ok & ~flush_rx;
    // Pushes at full are dropped silently; software polls tx_full
    tx_push_ok  = tx_push & ~tx_full;
  end

  // Sticky flags: a set event beats a clear in the same cycle
  always_comb begin
    rx_ovf_d = rx_ovf_q;
    tx_err_d = tx_err_q;
    if (clear_flags) begin
      rx_ovf_d = 1'b0;
      tx_err_d = 1'b0;
    end
    if (rx_ovf_set) rx_ovf_d = 1'b1;
    if (tx_err_set) tx_err_d = 1'b1;
  end

  // State register for synchronizers, flags and the TX FSM datapath
  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      rx_sync_q  <= '0;
      tx_sync_q  <= '0;
      rx_ovf_q   <= 1'b0;
      tx_err_q   <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_load_q  <= 1'b0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      rx_sync_q  <= rx_sync_d;
      tx_sync_q  <= tx_sync_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_err_q   <= tx_err_d;
      tx_state_q <= tx_state_d;
      tx_load_q  <= tx_load_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
    end
  end

  // TX FSM next-state
  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !flush_tx) tx_state_d = TX_LOAD;
      end
      TX_LOAD: begin
        if (flush_tx || tx_busy_s) begin
          tx_state_d = TX_DRAIN;
        end else if (cnt_q == CntLast) begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_DRAIN: begin
        if (!tx_busy_s) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX FSM outputs: load level, latched byte, timeout counter, FIFO pop
  always_comb begin
    tx_load_d  = tx_load_q;
    tx_data_d  = tx_data_q;
    cnt_d      = cnt_q;
    tx_pop     = 1'b0;
    tx_err_set = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !flush_tx) begin
          tx_data_d = tx_head;
          tx_load_d = 1'b1;
          cnt_d     = '0;
        end
      end
      TX_LOAD: begin
        if (flush_tx) begin
          // FIFO is being emptied, so no pop is needed here
          tx_load_d = 1'b0;
        end else if (tx_busy_s) begin
          tx_load_d = 1'b0;
          tx_pop    = 1'b1;
        end else if (cnt_q == CntLast) begin
          tx_load_d  = 1'b0;
          tx_pop     = 1'b1;
          tx_err_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      TX_DRAIN: begin
      end
      default: begin
        tx_load_d = 1'b0;
      end
    endcase
  end

  // Visor-facing read data and transmitter outputs
  always_comb begin
    uart_tx_data = tx_data_q;
    uart_tx_load = tx_load_q;
    rx_rd_data   = '0;
    rx_rd_data[RxValidBit] = ~rx_empty;
    rx_rd_data[7:0]        = rx_empty ? 8'h00 : rx_head;
    status                 = '0;
    status[StatRxNonempty] = ~rx_empty;
    status[StatTxFull]     = tx_full;
    status[StatRxOverflow] = rx_ovf_q;
    status[StatTxError]    = tx_err_q;
    status[StatTxIdle]     = (tx_state_q == TX_IDLE) & tx_empty;
    status[StatRxCount +: DEPTH_LOG2 + 1] = rx_count;
  end

  assign unused_tx_count = ^tx_count;

  dbg_byte_fifo #(
    .DepthLog2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk_i   (sysclk),
    .rst_ni  (sysreset_n),
    .push_i  (rx_fall),
    .pop_i   (rx_pop),
    .flush_i (flush_rx),
    .wdata_i (uart_rx_data),
    .head_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  dbg_byte_fifo #(
    .DepthLog2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk_i   (sysclk),
    .rst_ni  (sysreset_n),
    .push_i  (tx_push_ok),
    .pop_i   (tx_pop),
    .flush_i (flush_tx),
    .wdata_i (tx_wr_data),
    .head_o  (tx_head),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

endmodule
